// File: rtl/noc_local_injector.sv
// noc_local_injector
//   Packetizer at a mesh node's local port. Takes a packet request
//   (destination, length, VC) and a stream of payload beats from the core,
//   and emits a wormhole packet (head, body..., tail) into the router's local
//   receive port through a single registered output stage.
//
// Ports
//   noc_clk, noc_rst_n          clock, async active-low reset
//   id_x, id_y                  own node coordinates (static)
//   req_valid/req_ready         packet request handshake
//   req_dst_x, req_dst_y        destination node
//   req_len                     payload beats, 0..MAX_BEATS
//   req_vc                      virtual channel for the packet
//   data_valid/data_ready, data payload beat handshake
//   out_valid/out_ready         flit handshake toward router
//   out_vc_ready                per-VC space available at router
//   out_flit                    {type[1:0], vc, payload}
//   busy                        packet in progress
//   pkt_count                   packets fully sent (wraps)
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no packet open; head (or head+tail) loads on request fire
// S_DATA | head sent/queued; payload beats load until remain hits 0

module noc_local_injector #(
  parameter  int ID_X_WIDTH = 4,
  parameter  int ID_Y_WIDTH = 4,
  parameter  int DATA_WIDTH = 64,
  parameter  int VC_NUM     = 2,
  parameter  int MAX_BEATS  = 16,
  localparam int VC_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int LEN_W      = $clog2(MAX_BEATS + 1),
  localparam int FLIT_W     = 2 + VC_W + DATA_WIDTH
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic [ID_X_WIDTH-1:0] id_x,
  input  logic [ID_Y_WIDTH-1:0] id_y,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_X_WIDTH-1:0] req_dst_x,
  input  logic [ID_Y_WIDTH-1:0] req_dst_y,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [VC_W-1:0]       req_vc,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [VC_NUM-1:0]     out_vc_ready,
  output logic [FLIT_W-1:0]     out_flit,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  localparam int HDR_W = 2 * (ID_X_WIDTH + ID_Y_WIDTH) + LEN_W;

  localparam logic [1:0] FT_BODY     = 2'b00;
  localparam logic [1:0] FT_HEAD     = 2'b01;
  localparam logic [1:0] FT_TAIL     = 2'b10;
  localparam logic [1:0] FT_HEADTAIL = 2'b11;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t                  state_q, state_d;
  logic [VC_W-1:0]         vc_q, vc_d;
  logic [LEN_W-1:0]        remain_q, remain_d;
  logic                    started_q;

  logic                    slot_free;
  logic                    load;
  logic [1:0]              ld_type;
  logic [VC_W-1:0]         ld_vc;
  logic [DATA_WIDTH-1:0]   ld_payload;
  logic [DATA_WIDTH-1:0]   head_payload;

  // The output register can take a new flit when it is empty or its current
  // flit leaves this cycle.
  assign slot_free = !out_valid || out_ready;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    head_payload            = '0;
    head_payload[HDR_W-1:0] = {req_len, id_y, id_x, req_dst_y, req_dst_x};
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q   <= S_IDLE;
      vc_q      <= '0;
      remain_q  <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vc_q      <= vc_d;
      remain_q  <= remain_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    vc_d       = vc_q;
    remain_d   = remain_q;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    load       = 1'b0;
    ld_type    = FT_BODY;
    ld_vc      = vc_q;
    ld_payload = data;
    case (state_q)
      S_IDLE: begin
        // started_q keeps requests blocked until the first clock after reset.
        req_ready = started_q && slot_free && out_vc_ready[req_vc];
        if (req_valid && started_q && slot_free && out_vc_ready[req_vc]) begin
          load       = 1'b1;
          ld_vc      = req_vc;
          ld_payload = head_payload;
          vc_d       = req_vc;
          remain_d   = req_len;
          if (req_len == LEN_ZERO) begin
            ld_type = FT_HEADTAIL;
          end else begin
            ld_type = FT_HEAD;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        data_ready = slot_free && out_vc_ready[vc_q];
        if (data_valid && slot_free && out_vc_ready[vc_q]) begin
          load     = 1'b1;
          remain_d = remain_q - LEN_ONE;
          if (remain_q == LEN_ONE) begin
            ld_type = FT_TAIL;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A load only happens when slot_free, so a stalled flit is never
  // overwritten; a valid flit is never retracted when vc_ready drops.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_flit  <= {ld_type, ld_vc, ld_payload};
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

  // Type bit 1 is set only for tail and head+tail flits.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      pkt_count <= '0;
    end else if (out_valid && out_ready && out_flit[FLIT_W-1]) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_noc_local_injector.sv
module tb_noc_local_injector;

  localparam int FW = 67;

  logic          noc_clk = 1'b0;
  logic          noc_rst_n = 1'b0;
  logic [3:0]    id_x = '0, id_y = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_dst_x = '0, req_dst_y = '0;
  logic [4:0]    req_len = '0;
  logic [0:0]    req_vc = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [63:0]   data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    out_vc_ready = 2'b11;
  logic [FW-1:0] out_flit;
  logic          busy;
  logic [15:0]   pkt_count;

  int n_run = 0, n_fail = 0, cyc = 0;
  logic [FW-1:0] fq[$], eq[$];
  int fc[$];

  noc_local_injector dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .id_x(id_x), .id_y(id_y),
    .req_valid(req_valid), .req_ready(req_ready), .req_dst_x(req_dst_x),
    .req_dst_y(req_dst_y), .req_len(req_len), .req_vc(req_vc),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .out_vc_ready(out_vc_ready),
    .out_flit(out_flit), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 noc_clk = ~noc_clk;
  always @(posedge noc_clk) cyc <= cyc + 1;

  // Record every flit that will be accepted at the coming rising edge.
  always @(negedge noc_clk) begin
    if (out_valid && out_ready) begin
      fq.push_back(out_flit);
      fc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic v, input logic [63:0] p);
    return {t, v, p};
  endfunction

  function automatic logic [63:0] hp(input logic [3:0] dx, input logic [3:0] dy,
                                    input logic [3:0] sx, input logic [3:0] sy,
                                    input logic [4:0] len);
    return {43'd0, len, sy, sx, dy, dx};
  endfunction

  task automatic push_exp(input logic [3:0] dx, input logic [3:0] dy, input logic [4:0] len,
                          input logic vc, input logic [63:0] base);
    eq.push_back(fl((len == 0) ? 2'b11 : 2'b01, vc, hp(dx, dy, id_x, id_y, len)));
    for (int i = 0; i < int'(len); i++)
      eq.push_back(fl((i == int'(len) - 1) ? 2'b10 : 2'b00, vc, base + 64'(i)));
  endtask

  task automatic clear_q();
    fq.delete();
    fc.delete();
    eq.delete();
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, fq.size(), eq.size());
    for (int i = 0; i < fq.size() && i < eq.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), fq[i], eq[i]);
    clear_q();
  endtask

  task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [4:0] len,
                          input logic vc, input logic [63:0] base);
    int g;
    req_dst_x = dx; req_dst_y = dy; req_len = len; req_vc = vc;
    req_valid = 1'b1;
    #1;
    g = 0;
    while (!req_ready && g < 100) begin tick(); #1; g++; end
    if (g >= 100) check("req_wait_timeout", 1, 0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      data_valid = 1'b1;
      data = base + 64'(i);
      #1;
      g = 0;
      while (!data_ready && g < 100) begin tick(); #1; g++; end
      if (g >= 100) check("data_wait_timeout", 1, 0);
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (out_valid && g < 50) begin tick(); g++; end
    if (g >= 50) check("drain_timeout", 1, 0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flit", out_flit, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_count", pkt_count, 0);
    tick(); tick();
    noc_rst_n = 1'b1;
    #1;
    check("req_ready_before_first_clk", req_ready, 0);
    tick(); #1;
    check("req_ready_after_first_clk", req_ready, 1);

    // Basic 3-beat packet, hand-computed flits
    clear_q();
    eq.push_back(fl(2'b01, 1'b1, 64'h0000_0000_0003_0012));
    eq.push_back(fl(2'b00, 1'b1, 64'h10));
    eq.push_back(fl(2'b00, 1'b1, 64'h11));
    eq.push_back(fl(2'b10, 1'b1, 64'h12));
    send_pkt(4'd2, 4'd1, 5'd3, 1'b1, 64'h10);
    drain();
    if (fc.size() >= 4) check("t1_consecutive", fc[3] - fc[0], 3);
    check_stream("t1");
    check("t1_pkt_count", pkt_count, 1);

    // Zero-length packet: single head+tail flit
    send_pkt(4'd5, 4'd6, 5'd0, 1'b0, 64'h0);
    #1;
    check("t2_busy", busy, 0);
    check("t2_flit", out_flit, fl(2'b11, 1'b0, 64'h0000_0000_0000_0065));
    check("t2_req_ready_next", req_ready, 1);
    drain();
    clear_q();
    check("t2_pkt_count", pkt_count, 2);

    // Output stall during a 4-beat packet
    clear_q();
    push_exp(4'd1, 4'd2, 5'd4, 1'b0, 64'hA0);
    fork
      send_pkt(4'd1, 4'd2, 5'd4, 1'b0, 64'hA0);
      begin
        logic [FW-1:0] held;
        logic [0:5]    pat;
        held = '0;
        pat  = 6'b100111;
        tick();
        for (int i = 0; i < 6; i++) begin
          out_ready = pat[i];
          #1;
          if (i == 1) begin
            held = out_flit;
            check("t3_held_flit", held, fl(2'b00, 1'b0, 64'hA0));
            check("t3_req_ready_busy", req_ready, 0);
          end
          if (!pat[i]) begin
            check($sformatf("t3_stall_data_ready%0d", i), data_ready, 0);
            check($sformatf("t3_stall_valid%0d", i), out_valid, 1);
          end
          if (i == 2) check("t3_flit_stable", out_flit, held);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_stream("t3");
    check("t3_pkt_count", pkt_count, 3);

    // VC gating
    clear_q();
    push_exp(4'd4, 4'd4, 5'd2, 1'b1, 64'hC0);
    out_vc_ready = 2'b01;
    req_dst_x = 4'd4; req_dst_y = 4'd4; req_len = 5'd2; req_vc = 1'b1;
    req_valid = 1'b1;
    #1;
    check("t4_req_ready_blocked", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_no_flit%0d", i), out_valid, 0);
    end
    out_vc_ready = 2'b11;
    #1;
    check("t4_req_ready_open", req_ready, 1);
    tick();
    req_valid = 1'b0;
    out_ready = 1'b0;
    out_vc_ready = 2'b01;
    data_valid = 1'b1;
    data = 64'hC0;
    #1;
    check("t4_head_valid", out_valid, 1);
    check("t4_head_flit", out_flit, fl(2'b01, 1'b1, hp(4'd4, 4'd4, 4'd0, 4'd0, 5'd2)));
    check("t4_data_ready_vc_low", data_ready, 0);
    tick(); #1;
    check("t4_head_held", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("t4_head_left", out_valid, 0);
    check("t4_data_ready_still_low", data_ready, 0);
    out_vc_ready = 2'b11;
    #1;
    check("t4_data_ready_restored", data_ready, 1);
    tick();
    data = 64'hC1;
    tick();
    data_valid = 1'b0;
    drain();
    check_stream("t4");
    check("t4_pkt_count", pkt_count, 4);

    // Back-to-back packets, including a same-node destination
    clear_q();
    id_x = 4'd3; id_y = 4'd5;
    push_exp(4'd3, 4'd5, 5'd2, 1'b0, 64'hD0);
    push_exp(4'd7, 4'd0, 5'd2, 1'b0, 64'hE0);
    send_pkt(4'd3, 4'd5, 5'd2, 1'b0, 64'hD0);
    send_pkt(4'd7, 4'd0, 5'd2, 1'b0, 64'hE0);
    drain();
    if (fc.size() >= 6) check("t5_no_gap", fc[5] - fc[0], 5);
    check_stream("t5");
    check("t5_pkt_count", pkt_count, 6);

    // Reset in the middle of a 5-beat packet
    clear_q();
    req_dst_x = 4'd1; req_dst_y = 4'd1; req_len = 5'd5; req_vc = 1'b0;
    req_valid = 1'b1;
    #1;
    check("t6_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1;
      data = 64'hB0 + 64'(i);
      tick();
    end
    check("t6_pre_flits", fq.size(), 3);
    noc_rst_n = 1'b0;
    data_valid = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_pkt_count", pkt_count, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_out_flit", out_flit, 0);
    tick();
    clear_q();
    noc_rst_n = 1'b1;
    tick();
    push_exp(4'd2, 4'd2, 5'd1, 1'b1, 64'hF0);
    send_pkt(4'd2, 4'd2, 5'd1, 1'b1, 64'hF0);
    drain();
    check_stream("t6");
    check("t6_pkt_count", pkt_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_local_injector.md
# noc_local_injector

Packetizer at the local port of a mesh node: accepts a packet request (destination, length, VC) plus a stream of payload beats from the attached core and emits a wormhole packet of head, body and tail flits into the router's local receive port. It is the transmit end of the router's local flit interface and obeys that interface's valid/ready/vc_ready handshake. A registered output stage sustains one flit per cycle and holds the selected VC for the whole packet.

## Interface
Parameters:
- ID_X_WIDTH, 4, width of node X coordinate
- ID_Y_WIDTH, 4, width of node Y coordinate
- DATA_WIDTH, 64, flit payload width; must be ≥ 2*(ID_X_WIDTH+ID_Y_WIDTH)+LEN_W
- VC_NUM, 2, number of virtual channels; VC_W = max(1,$clog2(VC_NUM))
- MAX_BEATS, 16, max payload beats per packet; LEN_W = $clog2(MAX_BEATS+1)

Ports:
- noc_clk  in  1  clock (already decided)
- noc_rst_n  in  1  reset, asynchronous, active-low (already decided)
- id_x / id_y  in  ID_X_WIDTH / ID_Y_WIDTH  own node coordinates, static
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_dst_x / req_dst_y  in  ID_X_WIDTH / ID_Y_WIDTH  destination node
- req_len  in  LEN_W  payload beats, 0..MAX_BEATS
- req_vc  in  VC_W  virtual channel for the packet
- data_valid / data_ready  in / out  1  payload beat handshake
- data  in  DATA_WIDTH  payload beat
- out_valid  out  1  flit valid toward router
- out_ready  in  1  router accepts flit when out_valid && out_ready
- out_vc_ready  in  VC_NUM  per-VC space available at router
- out_flit  out  2+VC_W+DATA_WIDTH  {type[1:0], vc, payload}
- busy  out  1  packet in progress (state != IDLE)
- pkt_count  out  16  packets fully sent, wraps

## Operation
- Flit type: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 head+tail (len=0).
- Head payload, LSB first: dst_x, dst_y, src_x(id_x), src_y(id_y), len; remaining upper bits zero.
- Body/tail payload = data beat unmodified. Packet = 1 head + req_len data flits; last data flit is tail.
- slot_free = !out_valid || out_ready.
- FSM IDLE: req_ready = slot_free && out_vc_ready[req_vc]. On req fire: latch vc, len into remain; load head (type 11 if len=0); go DATA if len>0 else stay IDLE.
- FSM DATA: data_ready = slot_free && out_vc_ready[vc_lat]; req_ready=0. On data fire: load flit, remain--; remain 1→0 loads tail and returns to IDLE.
- Output register: on load, out_valid=1 and out_flit updated; if slot_free and no load, out_valid=0. Flit held stable while out_valid && !out_ready.
- vc_ready only gates loading; a flit already valid is not retracted if its vc_ready drops.
- pkt_count increments on out fire of tail or head+tail flit; wraps 0xFFFF→0.
- Same-node destination (dst == id) injected normally.
- req_len > MAX_BEATS: unsupported; no behaviour guaranteed.

## Timing
- Reset (async assert): out_valid=0, out_flit=0, req_ready=0 until first clock out of reset, data_ready=0, busy=0, pkt_count=0, FSM IDLE. Reset mid-packet discards partial packet; no tail emitted.
- req fire at edge N → head out_valid after edge N; first data beat may fire same cycle head is presented if out_ready=1.
- Steady state with out_ready=1 and vc_ready=1: one flit per cycle; packet of L beats occupies L+1 consecutive cycles.
- Tail and next request: IDLE reached after tail load; next head can load the cycle tail fires (back-to-back packets, no bubble).
- Stall: out_ready=0 → data_ready=0 next-cycle-combinationally; no beat lost or duplicated.
- All ready outputs combinational from state, out_valid, out_ready, out_vc_ready; no combinational path from data to out_flit.

## Test plan
- Reset then req(dst=(2,1), len=3, vc=1), id=(0,0), out_ready=1, vc_ready=2'b11 → 4 flits consecutive: head type 01 vc 1 payload dst_x=2,dst_y=1,len=3; two body 00; tail 10; pkt_count=1.
- req len=0 → single flit type 11, busy stays 0, pkt_count increments, next req accepted following cycle.
- out_ready toggled 1,0,0,1 during 4-beat packet → flits unchanged while stalled, data_ready=0 during stall, exact beat order 0xA0..0xA3 at output.
- out_vc_ready[1]=0 with req_vc=1 → req_ready=0, no flit; raise to 1 → head issued next edge; drop during DATA → data_ready=0, held flit remains valid.
- Two back-to-back len=2 packets on vc 0 → 6 flits in 6 cycles, no gap.
- Assert noc_rst_n=0 after 2nd body flit of len=5 packet → out_valid=0 immediately, pkt_count=0; after release new packet sent correctly.
